// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and conditional negate helper
// used by the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Wide enough for a 2*64-bit product; callers zero-extend
  // into it and truncate back with a size cast.
  localparam int MAX_W = 130;

  // Two's-complement negate when en=1. Serves as abs() when
  // en is the operand sign bit. Negation of the low n bits is
  // exact for any n, so it works for every WIDTH.
  function automatic logic [MAX_W-1:0] cond_neg(
    input logic [MAX_W-1:0] x,
    input logic             en
  );
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/ready bundle between EX stage and muldiv_unit.
// master drives start/op/cancel/a/b; slave returns busy/ready/hi/lo.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, cancel, a, b,
    input  busy, ready, hi, lo
  );

  modport slave (
    input  start, op, cancel, a, b,
    output busy, ready, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one radix-2 step; mode=0 shift-add multiply,
// mode=1 restoring divide. Ports: acc, operand, mode -> acc_next.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  operand,
  input  logic              mode,
  output logic [2*WIDTH:0]  acc_next
);

  // Multiply layout: {carry, upper half, multiplier bits}.
  // Divide layout:   {partial remainder (W+1), quotient/dividend}.
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] r;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   rem_new;

  always_comb begin
    sum = acc[2*WIDTH:WIDTH]
        + {1'b0, operand & {WIDTH{acc[0]}}};
    r = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
    diff = r - {2'b00, operand};
    ge = ~diff[WIDTH+1];
    rem_new = ge ? diff[WIDTH:0] : r[WIDTH:0];
    if (mode)
      acc_next = {rem_new, acc[WIDTH-2:0], ge};
    else
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into {hi,lo}.
// Ports: clk, rst (sync, active-high), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2*WIDTH+1;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             busy_q;
  logic             ready_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // op[0] = signed, op[1] = divide
  always_comb begin
    a_neg = bus.op[0] & bus.a[WIDTH-1];
    b_neg = bus.op[0] & bus.b[WIDTH-1];
    mag_a = WIDTH'(cond_neg(MAX_W'(bus.a), a_neg));
    mag_b = WIDTH'(cond_neg(MAX_W'(bus.b), b_neg));
    div_zero = bus.op[1] & (bus.b == '0);
  end

  muldiv_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .acc     (acc),
    .operand (opnd),
    .mode    (is_div),
    .acc_next(acc_next)
  );

  // Fix-up taken from the final step so hi/lo land on DONE entry.
  always_comb begin
    prod = (2*WIDTH)'(cond_neg(
      MAX_W'(acc_next[2*WIDTH-1:0]), neg_res));
    quo = WIDTH'(cond_neg(
      MAX_W'(acc_next[WIDTH-1:0]), neg_res));
    rem = WIDTH'(cond_neg(
      MAX_W'(acc_next[2*WIDTH:WIDTH]), neg_rem));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.cancel) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (div_zero) begin
              state   <= DONE;
              ready_q <= 1'b1;
              hi_q    <= bus.a;
              lo_q    <= '1;
            end else begin
              state   <= CALC;
              busy_q  <= 1'b1;
              cnt     <= CW'(WIDTH-1);
              is_div  <= bus.op[1];
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              opnd    <= bus.op[1] ? mag_b : mag_a;
              acc     <= {{(WIDTH+1){1'b0}},
                          bus.op[1] ? mag_a : mag_b};
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == '0) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            hi_q    <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
            lo_q    <= is_div ? quo : prod[WIDTH-1:0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
